// File: rtl/ppu_scanline_buffer.sv
// ppu_scanline_buffer
//   Ping-pong scanline buffer between the PPU pixel stream and the VGA driver.
//   One bank captures the current 256-pixel PPU line while the other replays a
//   completed line at 2x scale.
//   Each stored pixel is read for two VGA columns.
//   Each stored line is read for two VGA rows.
//
// Ports
//   clock        : system clock
//   reset        : synchronous active-low reset
//   pix_valid    : PPU pixel strobe
//   pix_x        : PPU column (0..255 valid)
//   pix_y        : PPU line (0..239 valid)
//   pix_index    : PPU palette index to store
//   rd_en        : VGA read strobe
//   rd_x         : VGA column
//   rd_y         : VGA row
//   rd_index     : registered palette index for the palette ROM
//   rd_valid     : rd_index belongs to the previous cycle's rd_en
//   bank_ready   : per-bank line-complete flags
//   underrun_cnt : saturating count of in-window reads from a not-ready bank
//   overrun_cnt  : saturating count of line starts into a still-ready bank

module ppu_scanline_buffer #(
    parameter int         H_OFFSET     = 64,
    parameter logic [4:0] BORDER_IDX   = 5'h0F,
    parameter logic [4:0] UNDERRUN_IDX = 5'h00,
    parameter int         CNT_W        = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic [8:0]       pix_x,
    input  logic [8:0]       pix_y,
    input  logic [4:0]       pix_index,
    input  logic             rd_en,
    input  logic [9:0]       rd_x,
    input  logic [9:0]       rd_y,
    output logic [4:0]       rd_index,
    output logic             rd_valid,
    output logic [1:0]       bank_ready,
    output logic [CNT_W-1:0] underrun_cnt,
    output logic [CNT_W-1:0] overrun_cnt
);

    localparam logic [9:0] X_LO   = 10'(H_OFFSET);
    localparam logic [9:0] X_HI   = 10'(H_OFFSET + 512);
    localparam logic [9:0] X_LAST = 10'(H_OFFSET + 511);

    typedef enum logic {
        IDLE,
        FILL
    } wr_state_t;

    wr_state_t state, state_nxt;

    // Bank in the address MSB: {bank, column}
    logic [4:0] mem [0:511];

    logic       wb, rb;
    logic       pix_ok, line_start, wr_en, line_done;
    logic       rd_in_win, rd_underrun, consume, ovr_hit;
    logic [9:0] rd_off;
    logic [7:0] rd_addr;
    logic [1:0] ready_nxt;
    logic       unused_rd_off;

    // ---------------- write side ----------------
    always_comb begin
        wb         = pix_y[0];
        pix_ok     = pix_valid && (pix_y < 9'd240) && !pix_x[8];
        line_start = pix_ok && (pix_x[7:0] == 8'd0);
        // A restart at column 0 is legal from either state; other columns only land in FILL
        wr_en      = pix_ok && ((state == FILL) || line_start);
        line_done  = wr_en && (pix_x[7:0] == 8'hFF);
        ovr_hit    = line_start && bank_ready[wb];
    end

    always_comb begin
        state_nxt = state;
        if (line_start)
            state_nxt = FILL;
        else if (line_done)
            state_nxt = IDLE;
    end

    always_ff @(posedge clock) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // RAM keeps its contents across reset
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[{wb, pix_x[7:0]}] <= pix_index;
    end

    // ---------------- read side ----------------
    always_comb begin
        rb            = rd_y[1];
        rd_in_win     = (rd_x >= X_LO) && (rd_x < X_HI) && (rd_y < 10'd480);
        rd_off        = rd_x - X_LO;
        rd_addr       = rd_off[8:1];
        unused_rd_off = ^{rd_off[9], rd_off[0]};
        rd_underrun   = rd_en && rd_in_win && !bank_ready[rb];
        consume       = rd_en && rd_in_win && rd_y[0] && (rd_x == X_LAST);
    end

    // Clears are applied first so a line completion on the same edge wins
    always_comb begin
        ready_nxt = bank_ready;
        if (consume)
            ready_nxt[rb] = 1'b0;
        if (line_start)
            ready_nxt[wb] = 1'b0;
        if (line_done)
            ready_nxt[wb] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_index     <= BORDER_IDX;
            rd_valid     <= 1'b0;
            bank_ready   <= 2'b00;
            underrun_cnt <= '0;
            overrun_cnt  <= '0;
        end else begin
            rd_valid   <= rd_en;
            bank_ready <= ready_nxt;
            if (rd_en) begin
                if (!rd_in_win)
                    rd_index <= BORDER_IDX;
                else if (!bank_ready[rb])
                    rd_index <= UNDERRUN_IDX;
                else
                    rd_index <= mem[{rb, rd_addr}]; // old data on a same-address write
            end
            if (rd_underrun && (underrun_cnt != '1))
                underrun_cnt <= underrun_cnt + 1'b1;
            if (ovr_hit && (overrun_cnt != '1))
                overrun_cnt <= overrun_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ppu_scanline_buffer.sv
// tb_ppu_scanline_buffer
//   Directed bench for ppu_scanline_buffer. A behavioural model of the
//   line buffer predicts each read, pushes it to a scoreboard queue, and the
//   value is popped and compared once the registered output appears.

module tb_ppu_scanline_buffer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       pix_valid = 1'b0;
    logic [8:0] pix_x = '0;
    logic [8:0] pix_y = '0;
    logic [4:0] pix_index = '0;
    logic       rd_en = 1'b0;
    logic [9:0] rd_x = '0;
    logic [9:0] rd_y = '0;
    logic [4:0] rd_index;
    logic       rd_valid;
    logic [1:0] bank_ready;
    logic [7:0] underrun_cnt;
    logic [7:0] overrun_cnt;

    ppu_scanline_buffer #(
        .H_OFFSET     (64),
        .BORDER_IDX   (5'h0F),
        .UNDERRUN_IDX (5'h00),
        .CNT_W        (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pix_valid    (pix_valid),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_index    (pix_index),
        .rd_en        (rd_en),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_index     (rd_index),
        .rd_valid     (rd_valid),
        .bank_ready   (bank_ready),
        .underrun_cnt (underrun_cnt),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clock = ~clock;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // reference model state
    int m_mem [2][256];
    bit m_rdy [2];
    bit m_fill;
    int m_und;
    int m_ov;
    int last_idx;
    int exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdy_vec();
        return {30'd0, m_rdy[1], m_rdy[0]};
    endfunction

    task automatic post_checks(input bit dr);
        check("rd_valid", {31'd0, rd_valid}, {31'd0, dr});
        if (dr) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                last_idx = exp_q.pop_front();
                check("rd_index", {27'd0, rd_index}, last_idx);
            end
        end else begin
            check("rd_hold", {27'd0, rd_index}, last_idx);
        end
        check("bank_ready", {30'd0, bank_ready}, rdy_vec());
        check("underrun_cnt", {24'd0, underrun_cnt}, m_und);
        check("overrun_cnt", {24'd0, overrun_cnt}, m_ov);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        pix_valid = 1'b0;
        rd_en     = 1'b0;
        @(posedge clock);
        #1;
        m_rdy[0] = 0;
        m_rdy[1] = 0;
        m_fill   = 0;
        m_und    = 0;
        m_ov     = 0;
        last_idx = 'h0F;
        exp_q.delete();
        check("rst_rd_index", {27'd0, rd_index}, 32'h0F);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_bank_ready", {30'd0, bank_ready}, 32'd0);
        check("rst_underrun", {24'd0, underrun_cnt}, 32'd0);
        check("rst_overrun", {24'd0, overrun_cnt}, 32'd0);
        reset = 1'b1;
    endtask

    // One clock: optional pixel write and optional VGA read on the same edge
    task automatic step(input bit dw, input int px, input int py, input int pidx,
                        input bit dr, input int rx, input int ry);
        bit n_rdy [2];
        bit acc, wbk, rbk, inwin;
        pix_valid = dw;
        pix_x     = px[8:0];
        pix_y     = py[8:0];
        pix_index = pidx[4:0];
        rd_en     = dr;
        rd_x      = rx[9:0];
        rd_y      = ry[9:0];

        n_rdy = m_rdy;
        rbk   = ry[1];
        inwin = (rx >= 64) && (rx < 576) && (ry < 480);
        if (dr) begin
            if (!inwin) begin
                exp_q.push_back('h0F);
            end else if (!m_rdy[rbk]) begin
                exp_q.push_back('h00);
                if (m_und < 255) m_und++;
            end else begin
                exp_q.push_back(m_mem[rbk][(rx - 64) / 2]);
            end
            if (inwin && ry[0] && rx == 575) n_rdy[rbk] = 0;
        end
        wbk = py[0];
        acc = dw && (py < 240) && (px < 256);
        if (acc && (m_fill || px == 0)) begin
            m_mem[wbk][px] = pidx;
            if (px == 0) begin
                if (m_rdy[wbk] && m_ov < 255) m_ov++;
                n_rdy[wbk] = 0;
                m_fill = 1;
            end
            if (px == 255) begin
                n_rdy[wbk] = 1;
                m_fill = 0;
            end
        end

        @(posedge clock);
        #1;
        m_rdy = n_rdy;
        post_checks(dr);
    endtask

    task automatic fill_line(input int py, input int from_x, input int to_x, input int fixed);
        for (int x = from_x; x <= to_x; x++)
            step(1, x, py, (fixed >= 0) ? fixed : (x % 32), 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clock);
        #1;
        do_reset();

        // Line 0 with index = x[4:0]
        fill_line(0, 0, 255, -1);
        check("fill0_ready", {30'd0, bank_ready}, 32'd1);
        step(0, 0, 0, 0, 1, 64, 0);
        check("rd64", {27'd0, rd_index}, 32'd0);
        step(0, 0, 0, 0, 1, 65, 0);
        check("rd65", {27'd0, rd_index}, 32'd0);
        step(0, 0, 0, 0, 1, 66, 0);
        check("rd66", {27'd0, rd_index}, 32'd1);
        step(0, 0, 0, 0, 1, 127, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Borders leave the underrun counter alone
        step(0, 0, 0, 0, 1, 10, 0);
        step(0, 0, 0, 0, 1, 600, 5);
        step(0, 0, 0, 0, 1, 576, 0);
        step(0, 0, 0, 0, 1, 100, 480);
        check("border_und", {24'd0, underrun_cnt}, 32'd0);

        // Bank 1 never written: underrun and saturation
        step(0, 0, 0, 0, 1, 100, 2);
        check("und_first", {24'd0, underrun_cnt}, 32'd1);
        for (int i = 0; i < 300; i++)
            step(0, 0, 0, 0, 1, 64 + (i % 512), 2);
        check("und_sat", {24'd0, underrun_cnt}, 32'd255);

        // Full consumption of both rows of line 0
        do_reset();
        fill_line(0, 0, 255, -1);
        for (int r = 0; r < 2; r++)
            for (int x = 64; x < 576; x++)
                step(0, 0, 0, 0, 1, x, r);
        check("consumed", {30'd0, bank_ready}, 32'd0);
        step(0, 0, 0, 0, 1, 64, 0);
        check("post_consume_und", {24'd0, underrun_cnt}, 32'd1);

        // Overrun: line 2 over unconsumed line 0, with a same-bank read on the start edge
        do_reset();
        fill_line(0, 0, 255, -1);
        step(1, 0, 2, 31, 1, 64, 0);
        check("rbw_old", {27'd0, rd_index}, 32'd0);
        check("ovr_cnt", {24'd0, overrun_cnt}, 32'd1);
        check("ovr_clear", {30'd0, bank_ready}, 32'd0);
        fill_line(2, 1, 254, 31);
        check("ovr_still_clear", {30'd0, bank_ready}, 32'd0);
        step(1, 255, 2, 31, 0, 0, 0);
        check("ovr_done", {30'd0, bank_ready}, 32'd1);
        step(0, 0, 0, 0, 1, 65, 0);
        check("new_line", {27'd0, rd_index}, 32'd31);

        // Out-of-range pixels are ignored
        step(1, 0, 240, 3, 0, 0, 0);
        step(1, 256, 0, 3, 0, 0, 0);
        check("ign_ovr", {24'd0, overrun_cnt}, 32'd1);

        // Reset mid-line abandons it; restart completes
        do_reset();
        fill_line(1, 0, 100, -1);
        do_reset();
        check("midrst_ready", {30'd0, bank_ready}, 32'd0);
        fill_line(1, 0, 255, -1);
        check("restart_ready", {30'd0, bank_ready}, 32'd2);

        // Restart inside FILL discards the partial line
        fill_line(0, 0, 50, 7);
        fill_line(0, 0, 255, 9);
        check("restart_fill", {30'd0, bank_ready}, 32'd3);

        // Set beats consume on the same bank and edge
        fill_line(3, 0, 254, 5);
        step(1, 255, 3, 5, 1, 575, 3);
        check("set_wins", {30'd0, bank_ready}, 32'd3);
        step(0, 0, 0, 0, 1, 575, 2);
        check("rd_line3", {27'd0, rd_index}, 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ppu_scanline_buffer.md
Name: ppu_scanline_buffer

Overview:
- Ping-pong scanline buffer between the PPU pixel stream and the VGA driver.
- Stores one complete 256-pixel PPU line of 5-bit palette indices while the previous line is replayed at 2x scale.
- Horizontal scale: each stored pixel is read twice. Vertical scale: each stored line is read for two VGA rows.
- Maps VGA (x,y) addresses to stored indices and drives the palette-index input of the palette ROM. Tracks line readiness and reports underrun/overrun.

Parameters:
- H_OFFSET, 64, first VGA column of the 512-wide active image.
- BORDER_IDX, 5'h0F, index output outside the active window.
- UNDERRUN_IDX, 5'h00, index output when the addressed bank is not ready.
- CNT_W, 8, width of the saturating error counters.

Ports:
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-low reset; sampled on rising clock.
- pix_valid  in  1  PPU pixel strobe.
- pix_x  in  9  PPU column, 0..255 valid.
- pix_y  in  9  PPU line, 0..239 valid.
- pix_index  in  5  PPU palette index.
- rd_en  in  1  VGA read strobe.
- rd_x  in  10  VGA column, 0..639.
- rd_y  in  10  VGA row, 0..479.
- rd_index  out  5  registered palette index.
- rd_valid  out  1  rd_index corresponds to the previous cycle's rd_en.
- bank_ready  out  2  per-bank line-complete flags.
- underrun_cnt  out  CNT_W  saturating count of reads from a not-ready bank.
- overrun_cnt  out  CNT_W  saturating count of line starts into a still-ready bank.

Behaviour:
- Reset (reset==0 at a clock edge):
  - rd_index=BORDER_IDX, rd_valid=0, bank_ready=2'b00, both counters 0, write FSM to IDLE.
  - RAM contents are not cleared.
  - Reset mid-line abandons the line; no ready flag is set.
- Storage: two banks of 256x5. Write bank wb = pix_y[0]. Read bank rb = rd_y[1] (source line = rd_y[9:1]).
- Write FSM, states IDLE and FILL:
  - IDLE -> FILL on pix_valid with pix_x==0 and pix_y<240.
    - If bank_ready[wb]==1 at that point: overrun_cnt increments (saturating), bank_ready[wb] is cleared, the write proceeds.
  - FILL: each pix_valid writes pix_index to bank wb at address pix_x[7:0].
  - FILL -> IDLE after the write with pix_x==255; bank_ready[wb] is set the same edge.
  - pix_x==0 received while in FILL restarts the line in the new wb; the partial line is discarded and its flag is not set.
  - pix_valid with pix_y>=240 or pix_x>=256 is ignored in all states.
- Read path, 1-cycle latency; rd_valid <= rd_en every cycle:
  - If rd_x<H_OFFSET, rd_x>=H_OFFSET+512, or rd_y>=480: rd_index=BORDER_IDX.
  - Else if bank_ready[rb]==0: rd_index=UNDERRUN_IDX and underrun_cnt increments (saturating at all ones).
  - Else rd_index = bank rb at address (rd_x-H_OFFSET)[8:1]. Subtraction is 10-bit unsigned and is evaluated only inside the window.
  - When rd_en is 0, rd_index holds its value.
- Consume rule:
  - A read with rd_y[0]==1 at column rd_x==H_OFFSET+511 clears bank_ready[rb] on the following edge; both VGA rows of the line have been shown.
  - If a write-side set and a consume-side clear hit the same bank on the same edge, the set wins.
- Simultaneous write and read:
  - Same bank: the read returns the old RAM data (read-before-write).
  - Different banks: independent.
- The counters saturate and never wrap; they clear only on reset.

Test Plan:
- Reset, then fill line y=0 with pix_index=x[4:0] -> bank_ready=2'b01 after x=255; reads at rd_y=0, rd_x=64,65,66 return 0,0,1 with rd_valid one cycle after rd_en.
- Read rd_x=10, rd_y=0 and rd_x=600, rd_y=5 -> rd_index=5'h0F; underrun_cnt unchanged.
- Read rd_y=2 (bank 1) with no line written -> rd_index=5'h00, underrun_cnt=1; repeat 300 reads -> underrun_cnt saturates at 255.
- Fill y=0, read rows 0 and 1 fully -> bank_ready[0] clears after rd_y=1, rd_x=575; a subsequent read of row 0 counts an underrun.
- Fill y=0, then start y=2 (same bank) without consumption -> overrun_cnt=1, bank_ready[0] cleared until x=255 of y=2.
- Assert reset at pix_x=100 of y=1 -> bank_ready=0; restarting y=1 at x=0 completes normally and sets bank_ready[1].
